// File: rtl/mcu_l2_pkg.sv
// Shared types and constants for the L2 DDR refill path.
package mcu_l2_pkg;

  localparam int unsigned BEAT_W         = 128;
  localparam int unsigned WORDS_PER_BEAT = 8;
  localparam logic [11:0] L2_WORDS_MAX   = 12'hFFF;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CHECK     = 2'd1,
    ST_REQ       = 2'd2,
    ST_WAIT_DATA = 2'd3
  } refill_state_e;

  typedef logic [BEAT_W-1:0] beat_t;

endpackage

// File: rtl/refill_beat_fifo.sv
// Skid FIFO holding DDR read beats until L2 port B is free of conflicts.
module refill_beat_fifo
  import mcu_l2_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic  clk_166M66,
  input  logic  mcu_sys_rst,
  input  logic  push,
  input  beat_t push_data,
  input  logic  pop,
  output beat_t head_c,
  output logic  full_c,
  output logic  empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  beat_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);
  assign do_push = push && !full_c;
  assign do_pop  = pop && !empty_c;
  assign head_c  = mem[rd_ptr];

  // Storage is not reset; only the pointers define validity.
  always_ff @(posedge clk_166M66) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk_166M66) begin
    if (mcu_sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/l2_ddr_refill_ctrl.sv
// Refills L2 from DDR in fixed bursts when the L2 unread level runs low.
module l2_ddr_refill_ctrl
  import mcu_l2_pkg::*;
#(
  parameter int unsigned BURST_BEATS   = 8,
  parameter logic [11:0] LOW_WATERMARK = 12'd1024,
  parameter int unsigned DDR_ADDR_W    = 28
) (
  input  logic                  clk_166M66,
  input  logic                  mcu_sys_rst,
  input  logic                  i_enable,
  input  logic                  i_start,
  input  logic [DDR_ADDR_W-1:0] i_base_addr,
  input  logic [11:0]           i_l2_unread_size,
  input  logic                  i_l1ddr_rw_conflicts,
  output logic                  o_ddr_operate_enable,
  output logic                  o_ddr_rw,
  output logic [127:0]          o_ddr_wdata,
  output logic                  o_mem_rd_req,
  output logic [DDR_ADDR_W-1:0] o_mem_rd_addr,
  output logic [3:0]            o_mem_rd_len,
  input  logic                  i_mem_rd_ack,
  input  logic                  i_mem_rd_valid,
  input  logic [127:0]          i_mem_rd_data,
  input  logic                  i_mem_rd_last,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam logic [3:0]  BEATS_4  = 4'(BURST_BEATS);
  localparam logic [12:0] BURST_WORDS = 13'(BURST_BEATS * WORDS_PER_BEAT);

  refill_state_e          state;
  refill_state_e          state_nxt;
  logic [DDR_ADDR_W-1:0]  addr;
  logic [3:0]             beat_cnt;
  logic                   err;
  logic                   cond_q;
  logic                   cond_c;
  logic                   in_wait;
  logic                   beat_push;
  logic                   frame_err;
  logic                   burst_done;
  logic                   drain;
  beat_t                  fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;

  // Refill is worthwhile only when L2 is low and the whole burst still fits.
  assign cond_c = i_enable
               && (i_l2_unread_size <= LOW_WATERMARK)
               && (({1'b0, i_l2_unread_size} + BURST_WORDS) <= 13'(L2_WORDS_MAX));

  assign in_wait    = (state == ST_WAIT_DATA);
  assign beat_push  = in_wait && i_mem_rd_valid && (beat_cnt != BEATS_4) && !fifo_full;
  assign frame_err  = in_wait && i_mem_rd_valid
                   && ((beat_cnt == BEATS_4)
                    || (i_mem_rd_last && ((beat_cnt + 4'd1) != BEATS_4)));
  assign burst_done = in_wait && (beat_cnt == BEATS_4) && fifo_empty;
  assign drain      = !fifo_empty && !i_l1ddr_rw_conflicts;

  refill_beat_fifo #(
    .DEPTH(8)
  ) u_fifo (
    .clk_166M66 (clk_166M66),
    .mcu_sys_rst(mcu_sys_rst),
    .push       (beat_push),
    .push_data  (i_mem_rd_data),
    .pop        (drain),
    .head_c     (fifo_head),
    .full_c     (fifo_full),
    .empty_c    (fifo_empty)
  );

  always_ff @(posedge clk_166M66) begin
    if (mcu_sys_rst) begin
      state    <= ST_IDLE;
      addr     <= '0;
      beat_cnt <= '0;
      err      <= 1'b0;
      cond_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cond_q <= cond_c;
      if ((state == ST_IDLE) && i_start) begin
        addr <= i_base_addr;
      end else if (burst_done) begin
        addr <= addr + DDR_ADDR_W'(BURST_BEATS);
      end
      if (state == ST_REQ) begin
        beat_cnt <= '0;
      end else if (beat_push) begin
        beat_cnt <= beat_cnt + 4'd1;
      end
      if ((state == ST_IDLE) && i_start) begin
        err <= 1'b0;
      end else if (frame_err) begin
        err <= 1'b1;
      end
    end
  end

  // Next state; enable loss is honoured only between bursts.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (i_start) state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (!i_enable)   state_nxt = ST_IDLE;
        else if (cond_q) state_nxt = ST_REQ;
      end
      ST_REQ:       if (i_mem_rd_ack) state_nxt = ST_WAIT_DATA;
      ST_WAIT_DATA: if (burst_done) state_nxt = i_enable ? ST_CHECK : ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  assign o_ddr_operate_enable = drain;
  assign o_ddr_rw             = drain;
  assign o_ddr_wdata          = drain ? fifo_head : '0;
  assign o_mem_rd_req         = (state == ST_REQ);
  assign o_mem_rd_addr        = addr;
  assign o_mem_rd_len         = (state == ST_REQ) ? BEATS_4 : 4'd0;
  assign o_busy               = (state != ST_IDLE) || !fifo_empty;
  assign o_err                = err;

endmodule

// File: tb/tb_l2_ddr_refill_ctrl.sv
// Directed bench for l2_ddr_refill_ctrl with a port-B write scoreboard.
module tb_l2_ddr_refill_ctrl;

  localparam int unsigned AW = 28;
  localparam int unsigned BB = 8;

  typedef struct {
    logic [127:0] data;
    int           due;
  } exp_t;

  logic          clk_166M66;
  logic          mcu_sys_rst;
  logic          i_enable;
  logic          i_start;
  logic [AW-1:0] i_base_addr;
  logic [11:0]   i_l2_unread_size;
  logic          i_l1ddr_rw_conflicts;
  logic          o_ddr_operate_enable;
  logic          o_ddr_rw;
  logic [127:0]  o_ddr_wdata;
  logic          o_mem_rd_req;
  logic [AW-1:0] o_mem_rd_addr;
  logic [3:0]    o_mem_rd_len;
  logic          i_mem_rd_ack;
  logic          i_mem_rd_valid;
  logic [127:0]  i_mem_rd_data;
  logic          i_mem_rd_last;
  logic          o_busy;
  logic          o_err;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t q[$];

  l2_ddr_refill_ctrl dut (
    .clk_166M66          (clk_166M66),
    .mcu_sys_rst         (mcu_sys_rst),
    .i_enable            (i_enable),
    .i_start             (i_start),
    .i_base_addr         (i_base_addr),
    .i_l2_unread_size    (i_l2_unread_size),
    .i_l1ddr_rw_conflicts(i_l1ddr_rw_conflicts),
    .o_ddr_operate_enable(o_ddr_operate_enable),
    .o_ddr_rw            (o_ddr_rw),
    .o_ddr_wdata         (o_ddr_wdata),
    .o_mem_rd_req        (o_mem_rd_req),
    .o_mem_rd_addr       (o_mem_rd_addr),
    .o_mem_rd_len        (o_mem_rd_len),
    .i_mem_rd_ack        (i_mem_rd_ack),
    .i_mem_rd_valid      (i_mem_rd_valid),
    .i_mem_rd_data       (i_mem_rd_data),
    .i_mem_rd_last       (i_mem_rd_last),
    .o_busy              (o_busy),
    .o_err               (o_err)
  );

  initial clk_166M66 = 1'b0;
  always #3 clk_166M66 = ~clk_166M66;

  always @(posedge clk_166M66) cyc <= cyc + 1;

  function automatic logic [127:0] beat(input logic [7:0] tag, input int i);
    logic [7:0] idx;
    idx = 8'(i);
    return {4{tag, idx, 16'hBEEF}};
  endfunction

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_166M66);
    #1;
  endtask

  task automatic wait_req(input logic [AW-1:0] exp_addr, output int waited);
    waited = 0;
    while (o_mem_rd_req !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    check("req_seen", o_mem_rd_req, 1'b1);
    check("req_addr", o_mem_rd_addr, exp_addr);
    check("req_len", o_mem_rd_len, 4'd8);
  endtask

  task automatic do_ack();
    tick();
    tick();
    i_mem_rd_ack = 1'b1;
    tick();
    i_mem_rd_ack = 1'b0;
    check("req_drop", o_mem_rd_req, 1'b0);
  endtask

  // Drives n beats back to back; only the first BB are expected to reach L2.
  task automatic run_burst(input logic [7:0] tag, input int n, input int last_idx, input bit exact);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      i_mem_rd_valid = 1'b1;
      i_mem_rd_data  = beat(tag, i);
      i_mem_rd_last  = (i == last_idx);
      if (i < BB) begin
        e.data = beat(tag, i);
        e.due  = exact ? cyc + 1 : 0;
        q.push_back(e);
      end
      tick();
    end
    i_mem_rd_valid = 1'b0;
    i_mem_rd_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("drain_done", q.size() == 0, 1'b1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req"}, o_mem_rd_req, 1'b0);
    check({tag, "_addr"}, o_mem_rd_addr, '0);
    check({tag, "_len"}, o_mem_rd_len, 4'd0);
    check({tag, "_en"}, o_ddr_operate_enable, 1'b0);
    check({tag, "_rw"}, o_ddr_rw, 1'b0);
    check({tag, "_wdata"}, o_ddr_wdata, '0);
    check({tag, "_busy"}, o_busy, 1'b0);
    check({tag, "_err"}, o_err, 1'b0);
  endtask

  // Port-B scoreboard: every write must match the next expected beat.
  always @(negedge clk_166M66) begin
    exp_t e;
    if (o_ddr_operate_enable === 1'b1) begin
      total++;
      assert (q.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_write obs=%0h exp=none", o_ddr_wdata);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        assert (o_ddr_wdata === e.data) else begin
          bad++;
          $error("FAIL wdata obs=%0h exp=%0h", o_ddr_wdata, e.data);
        end
        total++;
        assert (o_ddr_rw === 1'b1) else begin
          bad++;
          $error("FAIL rw obs=%0b exp=1", o_ddr_rw);
        end
        if (e.due != 0) begin
          total++;
          assert (cyc == e.due) else begin
            bad++;
            $error("FAIL write_cycle obs=%0d exp=%0d", cyc, e.due);
          end
        end
      end
    end
    if (i_l1ddr_rw_conflicts === 1'b1) begin
      total++;
      assert (o_ddr_operate_enable === 1'b0) else begin
        bad++;
        $error("FAIL conflict_en obs=%0b exp=0", o_ddr_operate_enable);
      end
    end
  end

  initial begin
    int w;
    bit seen;

    mcu_sys_rst          = 1'b1;
    i_enable             = 1'b0;
    i_start              = 1'b0;
    i_base_addr          = '0;
    i_l2_unread_size     = '0;
    i_l1ddr_rw_conflicts = 1'b0;
    i_mem_rd_ack         = 1'b0;
    i_mem_rd_valid       = 1'b0;
    i_mem_rd_data        = '0;
    i_mem_rd_last        = 1'b0;
    repeat (3) tick();
    mcu_sys_rst = 1'b0;
    check_idle_outputs("reset");

    // Basic burst at 0x100 with single-cycle write latency.
    i_enable    = 1'b1;
    i_base_addr = 28'h100;
    i_start     = 1'b1;
    tick();
    i_start = 1'b0;
    check("busy_after_start", o_busy, 1'b1);
    wait_req(28'h100, w);
    do_ack();
    run_burst(8'h01, 8, 7, 1'b1);
    wait_drain();
    wait_req(28'h108, w);

    // Watermark: 1025 blocks, 1024 requests two cycles later.
    i_l2_unread_size = 12'd1025;
    do_ack();
    run_burst(8'h02, 8, 7, 1'b1);
    wait_drain();
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen |= o_mem_rd_req;
    end
    check("no_req_1025", seen, 1'b0);
    i_l2_unread_size = 12'd1024;
    #1;
    check("req_low_now", o_mem_rd_req, 1'b0);
    wait_req(28'h110, w);
    check("req_latency", w, 2);

    // Conflict held over a whole burst, then drained in order.
    i_l2_unread_size     = 12'd4032;
    i_l1ddr_rw_conflicts = 1'b1;
    do_ack();
    run_burst(8'h03, 8, 7, 1'b0);
    repeat (3) tick();
    check("held_en", o_ddr_operate_enable, 1'b0);
    check("held_busy", o_busy, 1'b1);
    check("held_count", q.size(), 8);
    i_l1ddr_rw_conflicts = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      check("drain_consec", o_ddr_operate_enable, 1'b1);
      tick();
    end
    check("drain_stop", o_ddr_operate_enable, 1'b0);
    check("drain_all", q.size(), 0);
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen |= o_mem_rd_req;
    end
    check("no_req_4032", seen, 1'b0);

    // Early last on beat 5 plus a stray ninth beat.
    i_l2_unread_size = 12'd0;
    wait_req(28'h118, w);
    do_ack();
    run_burst(8'h04, 9, 4, 1'b1);
    wait_drain();
    check("err_set", o_err, 1'b1);
    wait_req(28'h120, w);
    check("err_sticky", o_err, 1'b1);

    // Enable drop finishes the burst and parks in IDLE.
    i_enable = 1'b0;
    do_ack();
    run_burst(8'h05, 8, 7, 1'b1);
    wait_drain();
    repeat (4) tick();
    check("idle_busy", o_busy, 1'b0);
    check("idle_req", o_mem_rd_req, 1'b0);

    // Address wrap at the top of DDR space.
    i_enable    = 1'b1;
    i_base_addr = 28'hFFFFFF8;
    i_start     = 1'b1;
    tick();
    i_start = 1'b0;
    check("err_cleared", o_err, 1'b0);
    wait_req(28'hFFFFFF8, w);
    do_ack();
    run_burst(8'h06, 8, 7, 1'b1);
    wait_drain();
    wait_req(28'h0000000, w);

    // Reset in the middle of a burst.
    do_ack();
    run_burst(8'h07, 3, 7, 1'b1);
    mcu_sys_rst    = 1'b1;
    i_mem_rd_valid = 1'b1;
    i_mem_rd_data  = beat(8'h07, 3);
    tick();
    mcu_sys_rst = 1'b0;
    check_idle_outputs("midrst");
    for (int i = 4; i < 8; i++) begin
      i_mem_rd_valid = 1'b1;
      i_mem_rd_data  = beat(8'h07, i);
      i_mem_rd_last  = (i == 7);
      tick();
    end
    i_mem_rd_valid = 1'b0;
    i_mem_rd_last  = 1'b0;
    repeat (3) tick();
    check("late_err", o_err, 1'b0);
    check("late_busy", o_busy, 1'b0);
    check("late_en", o_ddr_operate_enable, 1'b0);
    check("sb_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
